// File: rtl/sram_port_arbiter_if.sv
// Bus bundle between the fetch/load-store requesters, the arbiter and the SRAM port.
// The master side is the requesters plus the SRAM macro; the slave side is the arbiter.
interface sram_port_arbiter_if #(
  parameter int AW = 14,
  parameter int DW = 32
);
  logic          i_imem_req;
  logic [31:0]   i_imem_addr;
  logic          o_imem_gnt;
  logic          o_imem_rvalid;
  logic [DW-1:0] o_imem_rdata;
  logic          o_imem_err;

  logic          i_dmem_req;
  logic          i_dmem_we;
  logic [31:0]   i_dmem_addr;
  logic [DW-1:0] i_dmem_wdata;
  logic [3:0]    i_dmem_bmask;
  logic          o_dmem_gnt;
  logic          o_dmem_ack;
  logic [DW-1:0] o_dmem_rdata;
  logic          o_dmem_err;

  logic          o_sram_cs;
  logic          o_sram_wren;
  logic [AW-1:0] o_sram_addr;
  logic [DW-1:0] o_sram_wdata;
  logic [3:0]    o_sram_bmask;
  logic [DW-1:0] i_sram_rdata;

  modport master (
    output i_imem_req, i_imem_addr,
    input  o_imem_gnt, o_imem_rvalid, o_imem_rdata, o_imem_err,
    output i_dmem_req, i_dmem_we, i_dmem_addr, i_dmem_wdata, i_dmem_bmask,
    input  o_dmem_gnt, o_dmem_ack, o_dmem_rdata, o_dmem_err,
    input  o_sram_cs, o_sram_wren, o_sram_addr, o_sram_wdata, o_sram_bmask,
    output i_sram_rdata
  );

  modport slave (
    input  i_imem_req, i_imem_addr,
    output o_imem_gnt, o_imem_rvalid, o_imem_rdata, o_imem_err,
    input  i_dmem_req, i_dmem_we, i_dmem_addr, i_dmem_wdata, i_dmem_bmask,
    output o_dmem_gnt, o_dmem_ack, o_dmem_rdata, o_dmem_err,
    output o_sram_cs, o_sram_wren, o_sram_addr, o_sram_wdata, o_sram_bmask,
    input  i_sram_rdata
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// Shares one byte-masked SRAM port between instruction fetch and the load/store unit.
// Zero-cycle grant, fixed one-cycle response, bounded data streak so fetch cannot starve.
module sram_port_arbiter #(
  parameter int AW          = 14,
  parameter int DW          = 32,
  parameter int MAX_DSTREAK = 4
) (
  input logic               i_clk,
  input logic               i_reset,
  sram_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_IMEM = 2'd1,
    SRC_DMEM = 2'd2
  } rsp_src_t;

  logic [3:0] streak_reg, streak_next;
  rsp_src_t   rsp_src_reg, rsp_src_next;
  logic       rsp_err_reg, rsp_err_next;
  logic       rsp_we_reg, rsp_we_next;

  logic imem_gnt, dmem_gnt;
  logic imem_in_range, dmem_in_range;
  logic streak_full;
  logic imem_rvalid, dmem_ack;
  logic unused_addr_bits;

  assign imem_in_range = (bus.i_imem_addr[31:AW+2] == '0);
  assign dmem_in_range = (bus.i_dmem_addr[31:AW+2] == '0);
  assign streak_full   = (streak_reg == 4'(MAX_DSTREAK));

  // Byte offset within the word is meaningless on a word-wide port.
  assign unused_addr_bits = ^{bus.i_imem_addr[1:0], bus.i_dmem_addr[1:0]};

  always_comb begin
    imem_gnt = 1'b0;
    dmem_gnt = 1'b0;
    if (!i_reset) begin
      if (bus.i_imem_req && (!bus.i_dmem_req || streak_full)) begin
        imem_gnt = 1'b1;
      end else if (bus.i_dmem_req) begin
        dmem_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    streak_next = streak_reg;
    if (!bus.i_imem_req || imem_gnt) begin
      streak_next = 4'd0;
    end else if (dmem_gnt && !streak_full) begin
      streak_next = streak_reg + 4'd1;
    end
  end

  always_comb begin
    rsp_src_next = SRC_NONE;
    rsp_err_next = 1'b0;
    rsp_we_next  = 1'b0;
    if (imem_gnt) begin
      rsp_src_next = SRC_IMEM;
      rsp_err_next = !imem_in_range;
    end else if (dmem_gnt) begin
      rsp_src_next = SRC_DMEM;
      rsp_err_next = !dmem_in_range;
      rsp_we_next  = bus.i_dmem_we;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      streak_reg  <= 4'd0;
      rsp_src_reg <= SRC_NONE;
      rsp_err_reg <= 1'b0;
      rsp_we_reg  <= 1'b0;
    end else begin
      streak_reg  <= streak_next;
      rsp_src_reg <= rsp_src_next;
      rsp_err_reg <= rsp_err_next;
      rsp_we_reg  <= rsp_we_next;
    end
  end

  assign bus.o_imem_gnt = imem_gnt;
  assign bus.o_dmem_gnt = dmem_gnt;

  // Out-of-range requests are granted but never reach the macro.
  assign bus.o_sram_cs    = (imem_gnt && imem_in_range) || (dmem_gnt && dmem_in_range);
  assign bus.o_sram_wren  = dmem_gnt && dmem_in_range && bus.i_dmem_we;
  assign bus.o_sram_addr  = dmem_gnt ? bus.i_dmem_addr[AW+1:2] : bus.i_imem_addr[AW+1:2];
  assign bus.o_sram_wdata = bus.i_dmem_wdata;
  assign bus.o_sram_bmask = (dmem_gnt && bus.i_dmem_we) ? bus.i_dmem_bmask : 4'hF;

  // Gating with reset drops a response whose grant is interrupted by reset.
  assign imem_rvalid = !i_reset && (rsp_src_reg == SRC_IMEM);
  assign dmem_ack    = !i_reset && (rsp_src_reg == SRC_DMEM);

  assign bus.o_imem_rvalid = imem_rvalid;
  assign bus.o_imem_err    = imem_rvalid && rsp_err_reg;
  assign bus.o_imem_rdata  = (imem_rvalid && !rsp_err_reg) ? bus.i_sram_rdata : '0;

  assign bus.o_dmem_ack    = dmem_ack;
  assign bus.o_dmem_err    = dmem_ack && rsp_err_reg;
  assign bus.o_dmem_rdata  = (dmem_ack && !rsp_err_reg && !rsp_we_reg) ? bus.i_sram_rdata : '0;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a behavioural registered-read SRAM.
module tb_sram_port_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sram_port_arbiter_if #(.AW(14), .DW(32)) bus ();

  sram_port_arbiter #(.AW(14), .DW(32), .MAX_DSTREAK(4)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  // Behavioural SRAM: byte-masked write, registered read.
  logic [31:0] mem [0:16383];
  logic [31:0] sram_q;
  assign bus.i_sram_rdata = sram_q;

  always @(posedge clk) begin
    if (bus.o_sram_cs) begin
      if (bus.o_sram_wren) begin
        for (int b = 0; b < 4; b++)
          if (bus.o_sram_bmask[b]) mem[bus.o_sram_addr][8*b +: 8] = bus.o_sram_wdata[8*b +: 8];
      end else begin
        sram_q <= mem[bus.o_sram_addr];
      end
    end
  end

  typedef struct {
    logic        ireq;
    logic [31:0] iaddr;
    logic        dreq;
    logic        we;
    logic [31:0] daddr;
    logic [31:0] wdata;
    logic [3:0]  bmask;
    logic        exp_ig;
    logic        exp_dg;
    logic        exp_cs;
    logic        exp_wren;
    logic [13:0] exp_saddr;
    logic [3:0]  exp_bmask;
    logic        exp_iv;
    logic [31:0] exp_irdata;
    logic        exp_ierr;
    logic        exp_dack;
    logic [31:0] exp_drdata;
    logic        exp_derr;
  } vec_t;

  localparam int NVEC = 14;
  vec_t vecs [NVEC];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    bus.i_imem_req   = 1'b0;
    bus.i_imem_addr  = 32'h0;
    bus.i_dmem_req   = 1'b0;
    bus.i_dmem_we    = 1'b0;
    bus.i_dmem_addr  = 32'h0;
    bus.i_dmem_wdata = 32'h0;
    bus.i_dmem_bmask = 4'h0;
  endtask

  task automatic chk_rsp(input string tag, input logic iv, input logic [31:0] ird, input logic ie,
                         input logic da, input logic [31:0] drd, input logic de);
    chk({tag, " imem_rvalid"}, 32'(bus.o_imem_rvalid), 32'(iv));
    chk({tag, " imem_rdata"},  bus.o_imem_rdata, ird);
    chk({tag, " imem_err"},    32'(bus.o_imem_err), 32'(ie));
    chk({tag, " dmem_ack"},    32'(bus.o_dmem_ack), 32'(da));
    chk({tag, " dmem_rdata"},  bus.o_dmem_rdata, drd);
    chk({tag, " dmem_err"},    32'(bus.o_dmem_err), 32'(de));
  endtask

  logic exp_pat [12];
  logic prev_i;

  initial begin
    for (int k = 0; k < 16384; k++) mem[k] = 32'h5A00_0000 | 32'(k);
    mem[4] = 32'h0000_0013;
    mem[8] = 32'h1122_3344;
    sram_q = 32'h0;

    //           ireq  iaddr         dreq  we    daddr         wdata         bmask  ig    dg    cs    wren  saddr  bmask  iv    irdata        ierr  dack  drdata        derr
    vecs[0]  = '{1'b1, 32'h0000_0010, 1'b0, 1'b0, 32'h0,        32'h0,        4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 14'd4,  4'hF, 1'b1, 32'h0000_0013, 1'b0, 1'b0, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_0020, 32'hAABBCCDD, 4'h5, 1'b0, 1'b1, 1'b1, 1'b1, 14'd8,  4'h5, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0,        1'b0};
    vecs[2]  = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h0,        32'h0,        4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 14'd0,  4'hF, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,        1'b0};
    vecs[3]  = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0000_0022, 32'h0,       4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 14'd8,  4'hF, 1'b0, 32'h0,         1'b0, 1'b1, 32'h11BB33DD, 1'b0};
    vecs[4]  = '{1'b1, 32'h0001_0000, 1'b0, 1'b0, 32'h0,        32'h0,        4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 14'd0,  4'hF, 1'b1, 32'h0,         1'b1, 1'b0, 32'h0,        1'b0};
    vecs[5]  = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h8000_0000, 32'hFFFFFFFF, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0, 14'd0,  4'hF, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0,        1'b1};
    vecs[6]  = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0000_0000, 32'h0,       4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 14'd0,  4'hF, 1'b0, 32'h0,         1'b0, 1'b1, 32'h5A000000, 1'b0};
    vecs[7]  = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_0040, 32'hFFFFFFFF, 4'h0, 1'b0, 1'b1, 1'b1, 1'b1, 14'd16, 4'h0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0,        1'b0};
    vecs[8]  = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0000_0040, 32'h0,       4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 14'd16, 4'hF, 1'b0, 32'h0,         1'b0, 1'b1, 32'h5A000010, 1'b0};
    vecs[9]  = '{1'b1, 32'h0000_0017, 1'b0, 1'b0, 32'h0,        32'h0,        4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 14'd5,  4'hF, 1'b1, 32'h5A000005, 1'b0, 1'b0, 32'h0,        1'b0};
    vecs[10] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_0030, 32'hCAFEF00D, 4'hF, 1'b0, 1'b1, 1'b1, 1'b1, 14'd12, 4'hF, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0,        1'b0};
    vecs[11] = '{1'b1, 32'h0000_0018, 1'b0, 1'b0, 32'h0,        32'h0,        4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 14'd6,  4'hF, 1'b1, 32'h5A000006, 1'b0, 1'b0, 32'h0,        1'b0};
    vecs[12] = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0000_0030, 32'h0,       4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 14'd12, 4'hF, 1'b0, 32'h0,         1'b0, 1'b1, 32'hCAFEF00D, 1'b0};
    vecs[13] = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h0,        32'h0,        4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 14'd0,  4'hF, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,        1'b0};

    exp_pat = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    // Reset with both requests pending: nothing may be granted.
    rst = 1'b1;
    drive_idle();
    bus.i_imem_req  = 1'b1;
    bus.i_imem_addr = 32'h10;
    bus.i_dmem_req  = 1'b1;
    bus.i_dmem_we   = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1;
      chk("rst imem_gnt",  32'(bus.o_imem_gnt), 32'h0);
      chk("rst dmem_gnt",  32'(bus.o_dmem_gnt), 32'h0);
      chk("rst sram_cs",   32'(bus.o_sram_cs), 32'h0);
      chk("rst sram_wren", 32'(bus.o_sram_wren), 32'h0);
    end
    @(negedge clk);
    rst = 1'b0;
    drive_idle();
    #1;
    chk_rsp("post-rst", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);

    // Table-driven vectors; responses for vector i are checked while vector i+1 is applied.
    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      bus.i_imem_req   = vecs[i].ireq;
      bus.i_imem_addr  = vecs[i].iaddr;
      bus.i_dmem_req   = vecs[i].dreq;
      bus.i_dmem_we    = vecs[i].we;
      bus.i_dmem_addr  = vecs[i].daddr;
      bus.i_dmem_wdata = vecs[i].wdata;
      bus.i_dmem_bmask = vecs[i].bmask;
      #1;
      $display("vec %0d: ig=%b dg=%b cs=%b wren=%b saddr=%0d iv=%b ack=%b",
               i, bus.o_imem_gnt, bus.o_dmem_gnt, bus.o_sram_cs, bus.o_sram_wren,
               bus.o_sram_addr, bus.o_imem_rvalid, bus.o_dmem_ack);
      chk($sformatf("v%0d imem_gnt", i), 32'(bus.o_imem_gnt), 32'(vecs[i].exp_ig));
      chk($sformatf("v%0d dmem_gnt", i), 32'(bus.o_dmem_gnt), 32'(vecs[i].exp_dg));
      chk($sformatf("v%0d sram_cs", i),  32'(bus.o_sram_cs),  32'(vecs[i].exp_cs));
      if (vecs[i].exp_cs || !(vecs[i].exp_ig || vecs[i].exp_dg))
        chk($sformatf("v%0d sram_wren", i), 32'(bus.o_sram_wren), 32'(vecs[i].exp_wren));
      if (vecs[i].exp_cs) begin
        chk($sformatf("v%0d sram_addr", i),  32'(bus.o_sram_addr),  32'(vecs[i].exp_saddr));
        chk($sformatf("v%0d sram_bmask", i), 32'(bus.o_sram_bmask), 32'(vecs[i].exp_bmask));
      end
      if (i > 0)
        chk_rsp($sformatf("v%0d rsp", i - 1), vecs[i-1].exp_iv, vecs[i-1].exp_irdata, vecs[i-1].exp_ierr,
                vecs[i-1].exp_dack, vecs[i-1].exp_drdata, vecs[i-1].exp_derr);
    end
    @(negedge clk);
    drive_idle();
    #1;
    chk_rsp("tail rsp", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("mem[0] untouched", mem[0], 32'h5A000000);

    // Both requesters held high: data streak bounded at four.
    prev_i = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      bus.i_imem_req  = 1'b1;
      bus.i_imem_addr = 32'h10;
      bus.i_dmem_req  = 1'b1;
      bus.i_dmem_we   = 1'b0;
      bus.i_dmem_addr = 32'h0;
      #1;
      $display("streak cycle %0d: ig=%b dg=%b iv=%b ack=%b", c, bus.o_imem_gnt, bus.o_dmem_gnt,
               bus.o_imem_rvalid, bus.o_dmem_ack);
      chk($sformatf("streak c%0d imem_gnt", c), 32'(bus.o_imem_gnt), 32'(exp_pat[c]));
      chk($sformatf("streak c%0d dmem_gnt", c), 32'(bus.o_dmem_gnt), 32'(!exp_pat[c]));
      if (c > 0)
        chk_rsp($sformatf("streak c%0d rsp", c - 1), prev_i, prev_i ? 32'h13 : 32'h0, 1'b0,
                !prev_i, prev_i ? 32'h0 : 32'h5A000000, 1'b0);
      prev_i = exp_pat[c];
    end
    @(negedge clk);
    drive_idle();
    #1;
    chk_rsp("streak last rsp", prev_i, prev_i ? 32'h13 : 32'h0, 1'b0,
            !prev_i, prev_i ? 32'h0 : 32'h5A000000, 1'b0);

    // Reset asserted the cycle after a fetch grant drops that response.
    @(negedge clk);
    bus.i_imem_req  = 1'b1;
    bus.i_imem_addr = 32'h10;
    #1;
    chk("rstmid grant", 32'(bus.o_imem_gnt), 32'h1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    $display("reset mid-stream: ig=%b iv=%b", bus.o_imem_gnt, bus.o_imem_rvalid);
    chk("rstmid imem_gnt",    32'(bus.o_imem_gnt), 32'h0);
    chk("rstmid imem_rvalid", 32'(bus.o_imem_rvalid), 32'h0);
    @(negedge clk);
    bus.i_dmem_req = 1'b1;
    #1;
    chk("rstmid2 imem_gnt",    32'(bus.o_imem_gnt), 32'h0);
    chk("rstmid2 dmem_gnt",    32'(bus.o_dmem_gnt), 32'h0);
    chk("rstmid2 sram_cs",     32'(bus.o_sram_cs), 32'h0);
    chk("rstmid2 imem_rvalid", 32'(bus.o_imem_rvalid), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    bus.i_dmem_req = 1'b0;
    #1;
    chk("postrst imem_gnt",    32'(bus.o_imem_gnt), 32'h1);
    chk("postrst imem_rvalid", 32'(bus.o_imem_rvalid), 32'h0);
    @(negedge clk);
    drive_idle();
    #1;
    $display("post-reset fetch response: iv=%b rdata=%h", bus.o_imem_rvalid, bus.o_imem_rdata);
    chk("postrst rsp rvalid", 32'(bus.o_imem_rvalid), 32'h1);
    chk("postrst rsp rdata",  bus.o_imem_rdata, 32'h13);
    @(negedge clk);
    #1;
    chk("postrst quiet", 32'(bus.o_imem_rvalid), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
